vote_input_conditioner: RTL and testbench
=========================================

// Module: vote_input_conditioner
// PURPOSE
//  Front end for voting_machine: turns three raw, bouncing, asynchronous candidate buttons into
//  clean one-cycle vote pulses that drive its i_candidate_1..3 inputs directly.
//  Synchronises and debounces each button, then arbitrates the three buttons.
//  Enforces one vote per press and rejects simultaneous presses.
//  Applies a post-vote lockout, and stops issuing votes once voting is over.
// PARAMETERS
//  DEBOUNCE_CYCLES  4   consecutive stable synchronised samples needed to change a debounced level (>=1)
//  LOCKOUT_CYCLES   8   cycles with all buttons debounced-low required after a ballot before re-arming (>=1)
// PORTS
//  clk            in   1  system clock, rising edge
//  rst_n          in   1  reset; asynchronous assert, active-low
//  i_btn_1        in   1  raw candidate-1 button, asynchronous, may bounce
//  i_btn_2        in   1  raw candidate-2 button
//  i_btn_3        in   1  raw candidate-3 button
//  i_voting_over  in   1  synchronous; voting closed (same signal fed to voting_machine)
//  o_candidate_1  out  1  one-cycle vote pulse for candidate 1
//  o_candidate_2  out  1  one-cycle vote pulse for candidate 2
//  o_candidate_3  out  1  one-cycle vote pulse for candidate 3
//  o_invalid      out  1  one-cycle pulse: ballot rejected because >1 button was pressed
//  o_busy         out  1  high in HOLD/COOLDOWN (not ready for a new ballot)
//  o_closed       out  1  high in CLOSED
// BEHAVIOUR
//  - Reset (rst_n=0, async): sync flops, debounced levels, counters = 0; FSM=IDLE; all outputs 0.
//  - Sync: 2-flop synchroniser per button. Debounce: per-button counter, width $clog2(DEBOUNCE_CYCLES+1).
//    Counter increments while sync value != debounced level. It clears when they match.
//    On reaching DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
//  - rise_x = debounced level x went 0->1 this cycle.
//  - All outputs are registered. A clean press held stable produces its pulse
//    DEBOUNCE_CYCLES+3 rising edges after the first edge that samples it high.
//  - FSM states: IDLE, HOLD, COOLDOWN, CLOSED.
//    IDLE:     exactly one rise_x, other debounced levels low -> pulse o_candidate_x, go HOLD.
//              Two or more debounced levels high -> pulse o_invalid, go HOLD (no vote).
//              This covers simultaneous rises and a rise while another button is still held.
//    HOLD:     wait until all debounced levels are low -> COOLDOWN and load the lockout counter.
//              Further rises are ignored.
//    COOLDOWN: count LOCKOUT_CYCLES cycles, then go IDLE. Any debounced level high -> back to HOLD,
//              no pulse (press swallowed).
//    CLOSED:   no pulses ever. Leave only via reset.
//  - i_voting_over=1 in any state -> CLOSED at the next edge. o_closed=1 from that edge.
//    It has priority: a vote/invalid decision in the same cycle is suppressed.
//  - At most one of o_candidate_1..3/o_invalid is high in any cycle. Each pulse lasts exactly 1 cycle.
//  - Reset mid-operation (e.g. in HOLD with a button held): everything clears immediately.
//    After release, a still-held button is debounced again from 0 and counts as a new press.
// STRUCTURE
//  - vm_pkg: NUM_CANDIDATES=3; typedef enum logic [1:0] {IDLE,HOLD,COOLDOWN,CLOSED} vic_state_t.
//  - Sub-module button_debouncer (param DEBOUNCE_CYCLES; clk, rst_n, i_raw -> o_level, o_rise),
//    instantiated 3x. It contains the synchroniser and the debounce counter.
//  - Top: arbitration/FSM, lockout counter ($clog2(LOCKOUT_CYCLES+1) bits), output registers.
// TESTING  (DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=8)
//  1. Reset: hold rst_n=0 with buttons toggling -> all outputs 0; after release, o_busy=o_closed=0.
//  2. Clean press: i_btn_1=1 held 20 cycles -> exactly one o_candidate_1 pulse, 7 edges after press;
//     nothing else fires.
//  3. Bounce: i_btn_2 toggles every 2 cycles for 12 cycles, then stays 1 -> exactly one
//     o_candidate_2 pulse, 7 edges after it settles.
//  4. Simultaneous: i_btn_1, i_btn_3 rise in the same cycle -> one o_invalid pulse, no candidate
//     pulse, o_busy=1 until both released + 8 cycles.
//  5. Lockout: second i_btn_3 press debounced 3 cycles into COOLDOWN -> no pulse, returns to HOLD.
//     A press after full cooldown -> one o_candidate_3 pulse.
//  6. Close/reset: i_voting_over=1 on the pulse-decision cycle -> no pulse, o_closed=1 next cycle,
//     later presses ignored. rst_n=0 mid-HOLD -> outputs 0 immediately.

Source files
------------

// File: rtl/vm_pkg.sv
// Shared types for the voting front end: candidate count, conditioner FSM states
// and a helper that counts how many debounced buttons are currently held.
package vm_pkg;

    localparam int NUM_CANDIDATES = 3;

    typedef enum logic [1:0] {IDLE, HOLD, COOLDOWN, CLOSED} vic_state_t;

    function automatic logic [1:0] count_high(input logic [NUM_CANDIDATES-1:0] v);
        logic [1:0] n;
        n = '0;
        for (int i = 0; i < NUM_CANDIDATES; i++) begin
            n = n + 2'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser followed by a stability counter; o_level changes only after
// DEBOUNCE_CYCLES consecutive synchronised samples disagree with it.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1_q, sync2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;

    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        if (sync2_q != level_q) begin
            // the sample that brings the count to DEBOUNCE_CYCLES flips the level
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
                rise_d  = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= i_raw;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign o_level = level_q;
    assign o_rise  = rise_q;

endmodule

// File: rtl/vote_input_conditioner.sv
// Conditions three raw candidate buttons into clean one-cycle vote pulses, rejecting
// multi-button ballots and enforcing a post-ballot lockout until voting closes.
module vote_input_conditioner
    import vm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LOCKOUT_CYCLES  = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn_1,
    input  logic i_btn_2,
    input  logic i_btn_3,
    input  logic i_voting_over,
    output logic o_candidate_1,
    output logic o_candidate_2,
    output logic o_candidate_3,
    output logic o_invalid,
    output logic o_busy,
    output logic o_closed
);

    localparam int LOCK_W = $clog2(LOCKOUT_CYCLES + 1);

    logic [NUM_CANDIDATES-1:0] raw, level, rise;
    logic [1:0]                n_high;

    vic_state_t                state_q, state_d;
    logic [LOCK_W-1:0]         lock_q, lock_d;
    logic [NUM_CANDIDATES-1:0] cand_q, cand_d;
    logic                      invalid_q, invalid_d;
    logic                      busy_q, busy_d;
    logic                      closed_q, closed_d;

    assign raw = {i_btn_3, i_btn_2, i_btn_1};

    for (genvar g = 0; g < NUM_CANDIDATES; g++) begin : g_deb
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_raw  (raw[g]),
            .o_level(level[g]),
            .o_rise (rise[g])
        );
    end

    always_comb begin
        n_high    = count_high(level);
        state_d   = state_q;
        lock_d    = lock_q;
        cand_d    = '0;
        invalid_d = 1'b0;
        if (i_voting_over) begin
            state_d = CLOSED;
        end else begin
            case (state_q)
                IDLE: begin
                    if (n_high >= 2'd2) begin
                        invalid_d = 1'b1;
                        state_d   = HOLD;
                    end else if (n_high == 2'd1 && (rise & level) != '0) begin
                        cand_d  = rise & level;
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (n_high == 2'd0) begin
                        state_d = COOLDOWN;
                        lock_d  = LOCK_W'(LOCKOUT_CYCLES);
                    end
                end
                COOLDOWN: begin
                    // a press during lockout is swallowed and must be released again
                    if (n_high != 2'd0) begin
                        state_d = HOLD;
                    end else if (lock_q == LOCK_W'(1)) begin
                        state_d = IDLE;
                    end else begin
                        lock_d = lock_q - 1'b1;
                    end
                end
                CLOSED:  state_d = CLOSED;
                default: state_d = IDLE;
            endcase
        end
        busy_d   = (state_d == HOLD) || (state_d == COOLDOWN);
        closed_d = (state_d == CLOSED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            lock_q    <= '0;
            cand_q    <= '0;
            invalid_q <= 1'b0;
            busy_q    <= 1'b0;
            closed_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            lock_q    <= lock_d;
            cand_q    <= cand_d;
            invalid_q <= invalid_d;
            busy_q    <= busy_d;
            closed_q  <= closed_d;
        end
    end

    assign o_candidate_1 = cand_q[0];
    assign o_candidate_2 = cand_q[1];
    assign o_candidate_3 = cand_q[2];
    assign o_invalid     = invalid_q;
    assign o_busy        = busy_q;
    assign o_closed      = closed_q;

endmodule

// File: tb/tb_vote_input_conditioner.sv
// Bench for vote_input_conditioner: directed scenarios plus random button activity,
// every cycle compared against a behavioural model of the ballot rules.
`timescale 1ns/1ps
module tb_vote_input_conditioner;

    localparam int DEB  = 4;
    localparam int LOCK = 8;

    localparam int M_IDLE = 0, M_HOLD = 1, M_COOL = 2, M_CLOSED = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] btn = '0;
    logic       voting_over = 1'b0;
    logic       o_c1, o_c2, o_c3, o_inv, o_busy, o_closed;

    int errors = 0;
    int checks = 0;

    vote_input_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .LOCKOUT_CYCLES (LOCK)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_btn_1      (btn[0]),
        .i_btn_2      (btn[1]),
        .i_btn_3      (btn[2]),
        .i_voting_over(voting_over),
        .o_candidate_1(o_c1),
        .o_candidate_2(o_c2),
        .o_candidate_3(o_c3),
        .o_invalid    (o_inv),
        .o_busy       (o_busy),
        .o_closed     (o_closed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: raw samples reach the debouncer two edges late; a level flips
    // once DEB fresh samples all disagree with it. Ballot rules act one edge later.
    bit rawq[3][$];
    bit syncq[3][$];
    bit m_lvl[3];
    bit m_rise[3];
    int m_mode;
    int m_cool;
    int m_nh;
    bit e_c[3];
    bit e_inv, e_busy, e_closed;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 3; b++) begin
                rawq[b].delete();
                syncq[b].delete();
                m_lvl[b]  = 1'b0;
                m_rise[b] = 1'b0;
                e_c[b]    = 1'b0;
            end
            m_mode = M_IDLE; m_cool = 0;
            e_inv = 1'b0; e_busy = 1'b0; e_closed = 1'b0;
        end else begin
            m_nh = int'(m_lvl[0]) + int'(m_lvl[1]) + int'(m_lvl[2]);
            for (int b = 0; b < 3; b++) e_c[b] = 1'b0;
            e_inv = 1'b0;
            if (voting_over) begin
                m_mode = M_CLOSED;
            end else if (m_mode == M_IDLE) begin
                if (m_nh >= 2) begin
                    e_inv = 1'b1; m_mode = M_HOLD;
                end else if (m_nh == 1) begin
                    for (int b = 0; b < 3; b++) begin
                        if (m_rise[b]) begin e_c[b] = 1'b1; m_mode = M_HOLD; end
                    end
                end
            end else if (m_mode == M_HOLD) begin
                if (m_nh == 0) begin m_mode = M_COOL; m_cool = LOCK; end
            end else if (m_mode == M_COOL) begin
                if (m_nh != 0) m_mode = M_HOLD;
                else begin
                    m_cool--;
                    if (m_cool == 0) m_mode = M_IDLE;
                end
            end
            e_busy   = (m_mode == M_HOLD) || (m_mode == M_COOL);
            e_closed = (m_mode == M_CLOSED);

            for (int b = 0; b < 3; b++) begin
                bit s;
                bit all_diff;
                rawq[b].push_back(btn[b]);
                s = (rawq[b].size() >= 3) ? rawq[b][rawq[b].size() - 3] : 1'b0;
                if (rawq[b].size() > 3) void'(rawq[b].pop_front());
                syncq[b].push_back(s);
                if (syncq[b].size() > DEB) void'(syncq[b].pop_front());
                all_diff = (syncq[b].size() == DEB);
                foreach (syncq[b][k]) if (syncq[b][k] == m_lvl[b]) all_diff = 1'b0;
                m_rise[b] = 1'b0;
                if (all_diff) begin
                    m_lvl[b]  = !m_lvl[b];
                    m_rise[b] = m_lvl[b];
                    syncq[b].delete();
                end
            end
        end
    end

    int cnt_c[3] = '{0, 0, 0};
    int cnt_inv = 0;

    always @(negedge clk) begin
        chk("cand1",   o_c1,     e_c[0]);
        chk("cand2",   o_c2,     e_c[1]);
        chk("cand3",   o_c3,     e_c[2]);
        chk("invalid", o_inv,    e_inv);
        chk("busy",    o_busy,   e_busy);
        chk("closed",  o_closed, e_closed);
        chk("onehot",  int'(o_c1) + int'(o_c2) + int'(o_c3) + int'(o_inv) <= 1, 1);
        cnt_c[0] += int'(o_c1);
        cnt_c[1] += int'(o_c2);
        cnt_c[2] += int'(o_c3);
        cnt_inv  += int'(o_inv);
    end

    int snap_c[3];
    int snap_inv;
    int hold[3] = '{0, 0, 0};

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic snapshot();
        for (int b = 0; b < 3; b++) snap_c[b] = cnt_c[b];
        snap_inv = cnt_inv;
    endtask

    task automatic chk_counts(input string tag, input int d1, input int d2, input int d3, input int dinv);
        chk({tag, "_n1"},   cnt_c[0] - snap_c[0], d1);
        chk({tag, "_n2"},   cnt_c[1] - snap_c[1], d2);
        chk({tag, "_n3"},   cnt_c[2] - snap_c[2], d3);
        chk({tag, "_ninv"}, cnt_inv - snap_inv,   dinv);
    endtask

    initial begin
        // reset held while buttons chatter
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            btn = 3'($urandom_range(0, 7));
            chk("rst_outs", {o_c1, o_c2, o_c3, o_inv, o_busy, o_closed}, 0);
        end
        @(negedge clk); btn = '0;
        @(negedge clk); rst_n = 1'b1;
        wait_neg(3);
        chk("post_rst_busy", o_busy, 0);
        chk("post_rst_closed", o_closed, 0);

        // clean press
        snapshot();
        btn[0] = 1'b1;
        wait_neg(6); chk("clean_early", o_c1, 0);
        wait_neg(1); chk("clean_pulse", o_c1, 1);
        wait_neg(1); chk("clean_once", o_c1, 0);
        wait_neg(12); btn[0] = 1'b0;
        wait_neg(30);
        chk_counts("clean", 1, 0, 0, 0);

        // bouncing press
        snapshot();
        for (int i = 0; i < 12; i++) begin
            btn[1] = ((i % 4) < 2);
            @(negedge clk);
        end
        btn[1] = 1'b1;
        wait_neg(6); chk("bounce_early", o_c2, 0);
        wait_neg(1); chk("bounce_pulse", o_c2, 1);
        wait_neg(10); btn[1] = 1'b0;
        wait_neg(30);
        chk_counts("bounce", 0, 1, 0, 0);

        // simultaneous press
        snapshot();
        btn[0] = 1'b1; btn[2] = 1'b1;
        wait_neg(7); chk("simul_inv", o_inv, 1);
        wait_neg(8); btn[0] = 1'b0; btn[2] = 1'b0;
        wait_neg(14); chk("simul_busy_hold", o_busy, 1);
        wait_neg(1);  chk("simul_busy_free", o_busy, 0);
        wait_neg(10);
        chk_counts("simul", 0, 0, 0, 1);

        // press swallowed by lockout, then a press after full cooldown
        snapshot();
        btn[2] = 1'b1; wait_neg(10);
        btn[2] = 1'b0; wait_neg(4);
        btn[2] = 1'b1; wait_neg(12);
        chk("lock_busy", o_busy, 1);
        btn[2] = 1'b0; wait_neg(30);
        chk_counts("lock", 0, 0, 1, 0);
        snapshot();
        btn[2] = 1'b1;
        wait_neg(7); chk("relock_pulse", o_c3, 1);
        wait_neg(5); btn[2] = 1'b0;
        wait_neg(30);
        chk_counts("relock", 0, 0, 1, 0);

        // random button activity
        for (int i = 0; i < 2000; i++) begin
            for (int b = 0; b < 3; b++) begin
                if (hold[b] == 0) begin
                    btn[b]  = ($urandom_range(0, 3) == 0);
                    hold[b] = $urandom_range(1, 14);
                end else begin
                    hold[b]--;
                end
            end
            @(negedge clk);
        end
        btn = '0;
        wait_neg(30);

        // voting closes on the decision cycle
        snapshot();
        btn[1] = 1'b1;
        wait_neg(6); voting_over = 1'b1;
        wait_neg(1);
        chk("close_no_vote", o_c2, 0);
        chk("close_flag", o_closed, 1);
        voting_over = 1'b0;
        wait_neg(5); btn[1] = 1'b0;
        wait_neg(10); btn[0] = 1'b1;
        wait_neg(12); btn[0] = 1'b0;
        wait_neg(5);
        chk_counts("closed", 0, 0, 0, 0);
        chk("closed_sticky", o_closed, 1);

        // reset while a ballot is held
        rst_n = 1'b0; wait_neg(2);
        rst_n = 1'b1; wait_neg(3);
        chk("reopen_closed", o_closed, 0);
        btn[0] = 1'b1;
        wait_neg(10);
        chk("midhold_busy", o_busy, 1);
        #2 rst_n = 1'b0;
        #1 chk("midhold_rst", {o_c1, o_c2, o_c3, o_inv, o_busy, o_closed}, 0);
        @(negedge clk); rst_n = 1'b1;
        wait_neg(6); chk("repress_early", o_c1, 0);
        wait_neg(1); chk("repress_pulse", o_c1, 1);
        wait_neg(3); btn[0] = 1'b0;
        wait_neg(30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
